// File: rtl/learn_mode_ctrl.sv
// learn_mode_ctrl: sequencer for the "learn" game mode. It walks the song ROM
// one entry per display step and presents each entry to the falling-note
// display. At every step boundary (a "tick") it checks whether the player holds
// the keys shown in the bottom display row. On a miss, scrolling freezes until
// the player presses the right keys. Hits and misses are counted and saturate
// at 1023. After the last entry, DRAIN empty rows are scrolled in so the
// remaining notes leave the screen. Then the block parks in DONE.
//
// Ports
//   vga_clk, rst_n         clock and asynchronous active-low reset
//   start                  one-cycle pulse: start song from entry 0 (IDLE/DONE only)
//   abort                  return to IDLE immediately (counters kept)
//   key[7:0]               synchronised user keys, bit7=C .. bit1=B
//   bottom_note[7:0]       note bits currently in the bottom display row
//   rom_addr[9:0]          song ROM address
//   rom_data[9:0]          {note, shift}, sampled one cycle after rom_addr
//   note, shift,
//   output_ready           entry presented to the display
//   step                   one-cycle pulse: advance display by one row
//   busy, done             status
//   hit_cnt, miss_cnt      saturating score counters
module learn_mode_ctrl #(
  parameter int PERIOD   = 100000,
  parameter int SONG_LEN = 256,
  parameter int DRAIN    = 32
) (
  input  logic       vga_clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] key,
  input  logic [7:0] bottom_note,
  output logic [9:0] rom_addr,
  input  logic [9:0] rom_data,
  output logic [7:0] note,
  output logic [1:0] shift,
  output logic       output_ready,
  output logic       step,
  output logic       busy,
  output logic       done,
  output logic [9:0] hit_cnt,
  output logic [9:0] miss_cnt
);

  localparam int TW = $clog2(PERIOD + 2);
  localparam int DW = (DRAIN < 2) ? 1 : $clog2(DRAIN + 1);

  // A song entry spends FETCH + WAIT_ROM + PERIOD RUN cycles per step. Drain
  // rows have no fetch, so they count PERIOD+2 cycles to keep the same scroll
  // cadence on screen.
  localparam logic [TW-1:0] TICK_RUN   = TW'(PERIOD - 1);
  localparam logic [TW-1:0] TICK_DRAIN = TW'(PERIOD + 1);
  localparam logic [9:0]    LAST_ADDR  = 10'(SONG_LEN - 1);
  localparam logic [DW-1:0] LAST_DRAIN = DW'((DRAIN < 1) ? 0 : DRAIN - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, WAIT_ROM, RUN, HOLD, DRAIN_S, DONE
  } state_t;

  state_t        state;
  logic [9:0]    addr;
  logic [TW-1:0] tick;
  logic [DW-1:0] drain_cnt;
  logic          in_drain;

  logic pass;
  logic scored;
  logic adv;
  logic miss_evt;
  logic hit_evt;

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  // An empty bottom row always lets the display scroll. A non-empty row needs
  // the matching keys, and a match on a non-empty row scores a hit.
  assign pass   = (bottom_note == 8'h00) || (key == bottom_note);
  assign scored = (bottom_note != 8'h00) && (key == bottom_note);

  always_comb begin
    adv      = 1'b0;
    miss_evt = 1'b0;
    case (state)
      RUN: begin
        if (tick == TICK_RUN) begin
          adv      = pass;
          miss_evt = !pass;
        end
      end
      DRAIN_S: begin
        if (tick == TICK_DRAIN) begin
          adv      = pass;
          miss_evt = !pass;
        end
      end
      HOLD:    adv = (key == bottom_note);
      default: ;
    endcase
    hit_evt = adv && ((state == HOLD) || scored);
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      addr         <= '0;
      tick         <= '0;
      drain_cnt    <= '0;
      in_drain     <= 1'b0;
      rom_addr     <= '0;
      note         <= '0;
      shift        <= '0;
      output_ready <= 1'b0;
      step         <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      hit_cnt      <= '0;
      miss_cnt     <= '0;
    end else begin
      step <= 1'b0;
      if (abort) begin
        state        <= IDLE;
        output_ready <= 1'b0;
        note         <= '0;
        busy         <= 1'b0;
        done         <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (start) begin
              addr      <= '0;
              hit_cnt   <= '0;
              miss_cnt  <= '0;
              in_drain  <= 1'b0;
              drain_cnt <= '0;
              busy      <= 1'b1;
              done      <= 1'b0;
              state     <= FETCH;
            end
          end
          FETCH: begin
            rom_addr     <= addr;
            output_ready <= 1'b0;
            state        <= WAIT_ROM;
          end
          WAIT_ROM: begin
            note         <= rom_data[9:2];
            shift        <= rom_data[1:0];
            output_ready <= 1'b1;
            tick         <= '0;
            state        <= RUN;
          end
          RUN: if (tick != TICK_RUN) tick <= tick + 1'b1;
          DRAIN_S: if (tick != TICK_DRAIN) tick <= tick + 1'b1;
          default: ;
        endcase

        // Tick / hold resolution; overrides the state chosen above.
        if (miss_evt) begin
          miss_cnt <= sat_inc(miss_cnt);
          state    <= HOLD;
        end
        if (adv) begin
          step <= 1'b1;
          if (hit_evt) hit_cnt <= sat_inc(hit_cnt);
          if (in_drain) begin
            tick <= '0;
            if (drain_cnt == LAST_DRAIN) begin
              state        <= DONE;
              done         <= 1'b1;
              busy         <= 1'b0;
              output_ready <= 1'b0;
            end else begin
              drain_cnt <= drain_cnt + 1'b1;
              state     <= DRAIN_S;
            end
          end else begin
            addr <= addr + 10'd1;
            if (addr == LAST_ADDR) begin
              in_drain  <= 1'b1;
              drain_cnt <= '0;
              tick      <= '0;
              note      <= '0;
              if (DRAIN == 0) begin
                state        <= DONE;
                done         <= 1'b1;
                busy         <= 1'b0;
                output_ready <= 1'b0;
              end else begin
                output_ready <= 1'b1;
                state        <= DRAIN_S;
              end
            end else begin
              state <= FETCH;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_learn_mode_ctrl.sv
// Directed bench for learn_mode_ctrl. Instance u_dut uses a 3-entry song with
// PERIOD=4 and DRAIN=2. Instance u_long uses a full 1024-entry song to push the
// score counters into saturation. Cycle n means "just after the n-th rising
// edge counted from the edge that samples start".
module tb_learn_mode_ctrl;

  logic       vga_clk = 1'b0;
  logic       rst_n   = 1'b0;
  logic       start   = 1'b0;
  logic       abort   = 1'b0;
  logic [7:0] key     = '0;
  logic [7:0] bottom_note = '0;
  logic [9:0] rom_addr;
  logic [9:0] rom_data;
  logic [7:0] note;
  logic [1:0] shift;
  logic       output_ready, step, busy, done;
  logic [9:0] hit_cnt, miss_cnt;

  logic       start2 = 1'b0;
  logic [7:0] key2   = '0;
  logic [9:0] rom_addr2;
  logic [9:0] rom_data2;
  logic [7:0] note2;
  logic [1:0] shift2;
  logic       ready2, step2, busy2, done2;
  logic [9:0] hit2, miss2;

  int total = 0;
  int bad   = 0;

  always #5 vga_clk = ~vga_clk;

  learn_mode_ctrl #(.PERIOD(4), .SONG_LEN(3), .DRAIN(2)) u_dut (
    .vga_clk(vga_clk), .rst_n(rst_n), .start(start), .abort(abort),
    .key(key), .bottom_note(bottom_note), .rom_addr(rom_addr),
    .rom_data(rom_data), .note(note), .shift(shift),
    .output_ready(output_ready), .step(step), .busy(busy), .done(done),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  learn_mode_ctrl #(.PERIOD(4), .SONG_LEN(1024), .DRAIN(2)) u_long (
    .vga_clk(vga_clk), .rst_n(rst_n), .start(start2), .abort(1'b0),
    .key(key2), .bottom_note(8'h80), .rom_addr(rom_addr2),
    .rom_data(rom_data2), .note(note2), .shift(shift2),
    .output_ready(ready2), .step(step2), .busy(busy2), .done(done2),
    .hit_cnt(hit2), .miss_cnt(miss2)
  );

  always_comb begin
    case (rom_addr)
      10'd0:   rom_data = 10'h204;
      10'd1:   rom_data = 10'h000;
      10'd2:   rom_data = 10'h081;
      default: rom_data = 10'h000;
    endcase
  end

  assign rom_data2 = {rom_addr2[7:0], rom_addr2[1:0]};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge vga_clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_step", step, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", output_ready, 0);
    chk("rst_hit", hit_cnt, 0);
    chk("rst_miss", miss_cnt, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    chk("idle_busy", busy, 0);

    // Full song, empty bottom row: steps every 6 cycles, two drain rows
    do_start();
    chk("t1_busy0", busy, 1);
    for (int c = 1; c <= 31; c++) begin
      cyc(1);
      chk($sformatf("t1_step@%0d", c), step, (c % 6 == 0) && (c <= 30));
      if (c == 2) begin
        chk("t1_note0", note, 8'h81);
        chk("t1_shift0", shift, 0);
        chk("t1_ready0", output_ready, 1);
        chk("t1_addr0", rom_addr, 0);
      end
      if (c == 7) begin
        chk("t1_ready_drop", output_ready, 0);
        chk("t1_addr1", rom_addr, 1);
      end
      if (c == 8) begin
        chk("t1_note1", note, 8'h00);
        chk("t1_ready1", output_ready, 1);
      end
      if (c == 14) begin
        chk("t1_note2", note, 8'h20);
        chk("t1_shift2", shift, 1);
        chk("t1_addr2", rom_addr, 2);
      end
      if (c == 19) begin
        chk("t1_drain_note", note, 0);
        chk("t1_drain_shift", shift, 1);
        chk("t1_drain_ready", output_ready, 1);
        chk("t1_drain_busy", busy, 1);
      end
      if (c == 30) begin
        chk("t1_done", done, 1);
        chk("t1_done_busy", busy, 0);
        chk("t1_done_ready", output_ready, 0);
      end
    end
    chk("t1_hit", hit_cnt, 0);
    chk("t1_miss", miss_cnt, 0);
    chk("t1_done_hold", done, 1);

    // Miss at the first tick, then recover three cycles later (restart from DONE)
    bottom_note = 8'h80;
    key = 8'h00;
    do_start();
    chk("t2_done_clr", done, 0);
    cyc(6);
    chk("t2_nostep", step, 0);
    chk("t2_miss", miss_cnt, 1);
    chk("t2_hit0", hit_cnt, 0);
    cyc(2);
    chk("t2_hold_note", note, 8'h81);
    chk("t2_hold_ready", output_ready, 1);
    chk("t2_hold_step", step, 0);
    cyc(1);
    chk("t2_hold_step9", step, 0);
    key = 8'h80;
    cyc(1);
    chk("t2_step", step, 1);
    chk("t2_hit", hit_cnt, 1);
    chk("t2_miss_keep", miss_cnt, 1);
    key = 8'h00;
    bottom_note = 8'h00;
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    chk("t2_abort_busy", busy, 0);
    chk("t2_abort_ready", output_ready, 0);
    chk("t2_abort_note", note, 0);
    chk("t2_abort_hit", hit_cnt, 1);
    chk("t2_abort_miss", miss_cnt, 1);

    // Keys match at the tick: immediate step and hit; start while busy ignored
    bottom_note = 8'h02;
    key = 8'h02;
    do_start();
    cyc(2);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(3);
    chk("t3_step", step, 1);
    chk("t3_hit", hit_cnt, 1);
    chk("t3_miss", miss_cnt, 0);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;

    // Abort on the tick cycle wins over the step
    do_start();
    chk("t4_clr_hit", hit_cnt, 0);
    cyc(5);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    chk("t4_step", step, 0);
    chk("t4_busy", busy, 0);
    chk("t4_ready", output_ready, 0);
    chk("t4_hit", hit_cnt, 0);
    chk("t4_miss", miss_cnt, 0);
    cyc(6);
    chk("t4_idle_step", step, 0);

    // Reset during HOLD, then replay from entry 0
    bottom_note = 8'h80;
    key = 8'h00;
    do_start();
    cyc(6);
    chk("t5_miss", miss_cnt, 1);
    cyc(2);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_ready", output_ready, 0);
    chk("t5_rst_note", note, 0);
    chk("t5_rst_addr", rom_addr, 0);
    chk("t5_rst_miss", miss_cnt, 0);
    chk("t5_rst_hit", hit_cnt, 0);
    cyc(1);
    rst_n = 1'b1;
    bottom_note = 8'h00;
    cyc(3);
    chk("t5_idle_busy", busy, 0);
    do_start();
    cyc(1);
    chk("t5_addr", rom_addr, 0);
    cyc(1);
    chk("t5_note", note, 8'h81);
    cyc(4);
    chk("t5_step", step, 1);

    // 1024-entry song, a miss at every tick: counters saturate at 1023.
    // Keys match only on edges 7,14,21,... which is one edge after each tick.
    start2 = 1'b1;
    cyc(1);
    start2 = 1'b0;
    for (int c = 0; c <= 7190; c++) begin
      key2 = ((c + 1) % 7 == 0) ? 8'h80 : 8'h00;
      if (c == 7) chk("t6_first_step", step2, 1);
      if (c == 1400) begin
        chk("t6_miss200", miss2, 200);
        chk("t6_hit200", hit2, 200);
      end
      if (c == 7182) begin
        chk("t6_last_step", step2, 1);
        chk("t6_done", done2, 1);
      end
      cyc(1);
    end
    chk("t6_miss_sat", miss2, 1023);
    chk("t6_hit_sat", hit2, 1023);
    chk("t6_busy", busy2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
